// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing monitor. It samples an hs/vs/de stream on pixel
//   strobes, recovers the (DrawX, DrawY) coordinate of each sample, checks the
//   sync edges against the configured timing, acquires lock and counts errors.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high
//   pix_ce       pixel strobe; the stream is sampled only when pix_ce=1
//   hs, vs       horizontal / vertical sync, active-low
//   de           display enable, 1 = visible pixel
//   locked       timing locked
//   DrawX/DrawY  recovered coordinate of the most recent sample
//   pixel_valid  locked and the coordinate lies in the visible area
//   frame_start  1-Clk pulse when locked and the sample coordinate is (0,0)
//   sync_err     1-Clk pulse on hs/vs timing mismatch
//   de_err       1-Clk pulse on de mismatch while locked
//   err_count    saturating count of error samples (sync_err or de_err)
module vga_sync_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_VISIBLE    = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pix_ce,
  input  logic       hs,
  input  logic       vs,
  input  logic       de,
  output logic       locked,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       sync_err,
  output logic       de_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state, state_n;
  logic       hs_prev, vs_prev;
  logic [3:0] good_frames, good_n;
  logic [9:0] nxt_x, nxt_y, x_n, y_n;
  logic       hs_fall, vs_fall, h_bad, v_bad, de_exp;
  logic       sync_err_n, de_err_n, frame_start_n;
  logic [7:0] err_n;

  assign hs_fall = hs_prev & ~hs;
  assign vs_fall = vs_prev & ~vs;

  // Coordinate this sample would have if the stream is on time.
  assign nxt_x = (DrawX == H_LAST) ? 10'd0 : DrawX + 10'd1;
  assign nxt_y = (DrawX != H_LAST) ? DrawY :
                 (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;

  // A sync edge is wrong both when it is missing and when it is unexpected.
  assign h_bad  = hs_fall ^ (nxt_x == H_SS);
  assign v_bad  = vs_fall ^ ((nxt_x == 10'd0) && (nxt_y == V_SS));
  assign de_exp = (nxt_x < H_VIS) && (nxt_y < V_VIS);

  always_comb begin
    state_n       = state;
    x_n           = DrawX;
    y_n           = DrawY;
    good_n        = good_frames;
    sync_err_n    = 1'b0;
    de_err_n      = 1'b0;
    frame_start_n = 1'b0;
    err_n         = err_count;
    case (state)
      SEARCH: begin
        // First vs edge seen is taken as the start of the vs-low line.
        if (vs_fall) begin
          x_n     = 10'd0;
          y_n     = V_SS;
          good_n  = 4'd0;
          state_n = TRACK;
        end
      end
      default: begin
        x_n = nxt_x;
        y_n = nxt_y;
        if (state == LOCKED) begin
          de_err_n      = (de != de_exp);
          frame_start_n = (nxt_x == 10'd0) && (nxt_y == 10'd0);
        end
        if (h_bad || v_bad) begin
          sync_err_n = 1'b1;
          good_n     = 4'd0;
          state_n    = SEARCH;
        end else if (vs_fall) begin
          if (good_frames != 4'hf) good_n = good_frames + 4'd1;
          if (state == TRACK && good_n >= LOCK_N) state_n = LOCKED;
        end
        // Coincident sync and de errors count as one event.
        if ((sync_err_n || de_err_n) && err_count != 8'hff)
          err_n = err_count + 8'd1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= SEARCH;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      good_frames <= 4'd0;
      locked      <= 1'b0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      de_err      <= 1'b0;
      err_count   <= 8'd0;
    end else if (pix_ce) begin
      state       <= state_n;
      DrawX       <= x_n;
      DrawY       <= y_n;
      hs_prev     <= hs;
      vs_prev     <= vs;
      good_frames <= good_n;
      locked      <= (state_n == LOCKED);
      pixel_valid <= (state_n == LOCKED) && (x_n < H_VIS) && (y_n < V_VIS);
      frame_start <= frame_start_n;
      sync_err    <= sync_err_n;
      de_err      <= de_err_n;
      err_count   <= err_n;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      de_err      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a shrunk timing (24x12 samples per frame)
// so several frames fit in a short run. A bench-side stream generator drives
// the VGA signals; a reference model pushes expected outputs per sample and
// the DUT outputs are captured after each sample for comparison.
module tb_vga_sync_decoder;
  localparam int HV = 16, HT = 24, HSS = 18, HSE = 22;
  localparam int VV = 8,  VT = 12, VSS = 9,  VSE = 11;
  localparam int LOCKF = 2;

  logic       Clk = 1'b0, Reset = 1'b0, pix_ce = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic       locked, pixel_valid, frame_start, sync_err, de_err;
  logic [9:0] DrawX, DrawY;
  logic [7:0] err_count;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       lk;
    logic       pv;
    logic       fs;
    logic       se;
    logic       de;
    logic [7:0] cnt;
  } obs_t;

  obs_t sb[$];
  obs_t ob[$];
  int   errors = 0, checks = 0;

  // reference model state
  int   m_st, mx, my, m_gf, m_cnt;
  logic m_hp, m_vp;
  // stream generator position and last driven coordinate
  int   gx = 0, gy = 0, lx = 0, ly = 0;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_FRAMES(LOCKF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .hs(hs), .vs(vs), .de(de),
    .locked(locked), .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .sync_err(sync_err), .de_err(de_err),
    .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_st = 0; mx = 0; my = 0; m_gf = 0; m_cnt = 0; m_hp = 1'b1; m_vp = 1'b1;
  endtask

  // One sample of the expected behaviour; m_st 0=search 1=track 2=locked.
  task automatic model_step(input logic h, input logic v, input logic d);
    logic hf, vf, hb, vb, want_de;
    int   nx, ny;
    obs_t e;
    hf = m_hp & ~h; vf = m_vp & ~v; m_hp = h; m_vp = v;
    e = '0;
    if (m_st == 0) begin
      if (vf) begin mx = 0; my = VSS; m_gf = 0; m_st = 1; end
    end else begin
      nx = (mx == HT-1) ? 0 : mx + 1;
      ny = (mx != HT-1) ? my : ((my == VT-1) ? 0 : my + 1);
      mx = nx; my = ny;
      hb = hf != (nx == HSS);
      vb = vf != (nx == 0 && ny == VSS);
      if (m_st == 2) begin
        want_de = (nx < HV) && (ny < VV);
        e.de = (d != want_de);
        e.fs = (nx == 0 && ny == 0);
      end
      if (hb || vb) begin
        e.se = 1'b1; m_gf = 0; m_st = 0;
      end else if (vf) begin
        if (m_gf < 15) m_gf++;
        if (m_st == 1 && m_gf == LOCKF) m_st = 2;
      end
      if ((e.se || e.de) && m_cnt < 255) m_cnt++;
    end
    e.x = 10'(mx); e.y = 10'(my); e.lk = (m_st == 2);
    e.pv = e.lk && mx < HV && my < VV; e.cnt = 8'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic drive_raw(input int gap, input logic h, input logic v, input logic d);
    obs_t o;
    repeat (gap) begin pix_ce = 1'b0; @(posedge Clk); #1; end
    hs = h; vs = v; de = d; pix_ce = 1'b1;
    model_step(h, v, d);
    @(posedge Clk); #1;
    o = {DrawX, DrawY, locked, pixel_valid, frame_start, sync_err, de_err, err_count};
    ob.push_back(o);
    pix_ce = 1'b0;
  endtask

  task automatic gen_sig(output logic h, output logic v, output logic d);
    h = !(gx >= HSS && gx < HSE);
    v = !(gy >= VSS && gy < VSE);
    d = (gx < HV) && (gy < VV);
  endtask

  task automatic gen_adv();
    lx = gx; ly = gy;
    gx++;
    if (gx == HT) begin gx = 0; gy = (gy == VT-1) ? 0 : gy + 1; end
  endtask

  task automatic gen_drive(input int gap, input logic kill_h, input logic flip_de);
    logic h, v, d;
    gen_sig(h, v, d);
    drive_raw(gap, h | kill_h, v, d ^ flip_de);
    gen_adv();
  endtask

  // Drive the clean stream until the sample at (x,y) has been driven.
  task automatic run_to(input int x, input int y, input bit rnd);
    for (int n = 0; n < 2*HT*VT; n++) begin
      gen_drive(rnd ? int'($urandom_range(1, 5)) : 1, 1'b0, 1'b0);
      if (lx == x && ly == y) return;
    end
    checks++; errors++;
    $display("FAIL run_to(%0d,%0d) not reached", x, y);
  endtask

  task automatic test_reset();
    obs_t o;
    Reset = 1'b1; pix_ce = 1'b1;
    repeat (3) @(posedge Clk);
    #1; Reset = 1'b0; pix_ce = 1'b0;
    model_reset();
    o = {DrawX, DrawY, locked, pixel_valid, frame_start, sync_err, de_err, err_count};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_state got %h want 0", o); end
  endtask

  task automatic test_lock();
    obs_t e, o;
    int first_lock = -1, n_fs = 0, n_se = 0;
    for (int i = 0; i < 1200; i++) begin
      gen_drive(1, 1'b0, 1'b0);
      if (i == 215) begin
        checks++;
        if (DrawY !== 10'd0) begin errors++; $display("FAIL search_hold y=%0d want 0", DrawY); end
      end
      if (i == 216) begin
        checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'(VSS)) begin
          errors++; $display("FAIL track_entry got (%0d,%0d) want (0,%0d)", DrawX, DrawY, VSS);
        end
      end
      if (locked && first_lock < 0) first_lock = i;
      if (frame_start) n_fs++;
      if (sync_err) n_se++;
    end
    checks++;
    if (first_lock != 792) begin errors++; $display("FAIL lock_time got %0d want 792", first_lock); end
    checks++;
    if (n_fs != 2) begin errors++; $display("FAIL frame_start_count got %0d want 2", n_fs); end
    checks++;
    if (n_se != 0) begin errors++; $display("FAIL lock_sync_err got %0d want 0", n_se); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lock_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_hs_drop();
    obs_t e, o;
    run_to(HSS-1, 3, 1'b0);
    gen_drive(1, 1'b1, 1'b0);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || DrawX !== 10'(HSS)) begin
      errors++;
      $display("FAIL hs_drop se=%b lk=%b cnt=%0d x=%0d want 1 0 1 %0d", sync_err, locked, err_count, DrawX, HSS);
    end
    repeat (HSE-HSS-1) gen_drive(1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_to(0, VSS, 1'b0);
      checks++;
      if (locked !== (k == 2)) begin errors++; $display("FAIL relock vs#%0d locked=%b want %b", k, locked, k == 2); end
    end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL hs_drop_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_de_err();
    obs_t e, o;
    run_to(HV, 5, 1'b0);
    gen_drive(1, 1'b0, 1'b1);
    checks++;
    if (de_err !== 1'b1 || err_count !== 8'd2 || locked !== 1'b1 || DrawX !== 10'(HV+1)) begin
      errors++;
      $display("FAIL de_err de=%b cnt=%0d lk=%b x=%0d want 1 2 1 %0d", de_err, err_count, locked, DrawX, HV+1);
    end
    for (int k = 2; k <= 3; k++) begin
      gen_drive(1, 1'b0, 1'b0);
      checks++;
      if (DrawX !== 10'(HV+k) || de_err !== 1'b0 || err_count !== 8'd2) begin
        errors++; $display("FAIL de_after x=%0d de=%b cnt=%0d want %0d 0 2", DrawX, de_err, err_count, HV+k);
      end
    end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL de_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    logic h, v, d;
    run_to(5, 3, 1'b0);
    gen_sig(h, v, d);
    hs = h; vs = v; de = d; pix_ce = 1'b1; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; pix_ce = 1'b0;
    gen_adv(); model_reset();
    o = {DrawX, DrawY, locked, pixel_valid, frame_start, sync_err, de_err, err_count};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_mid got %h want 0", o); end
    run_to(HT-1, VSS-1, 1'b0);
    checks++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL reset_search got (%0d,%0d) lk=%b want (0,0) 0", DrawX, DrawY, locked);
    end
    gen_drive(1, 1'b0, 1'b0);
    checks++;
    if (DrawY !== 10'(VSS)) begin errors++; $display("FAIL reset_reacq y=%0d want %0d", DrawY, VSS); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_gaps();
    obs_t e, o;
    run_to(0, VSS, 1'b1);
    run_to(0, VSS, 1'b1);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd0) begin
      errors++; $display("FAIL gap_lock lk=%b cnt=%0d want 1 0", locked, err_count);
    end
    run_to(0, 0, 1'b1);
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL gap_fs got %b want 1", frame_start); end
    pix_ce = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (frame_start !== 1'b0 || DrawX !== 10'd0 || DrawY !== 10'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL idle_hold fs=%b (%0d,%0d) lk=%b want 0 (0,0) 1", frame_start, DrawX, DrawY, locked);
    end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL gap_sb got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturate();
    obs_t e, o;
    int n_se = 0;
    Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
    model_reset();
    // vs edge arms TRACK, then an hs edge at the wrong place drops it again
    for (int i = 1; i <= 300; i++) begin
      drive_raw(0, 1'b1, 1'b1, 1'b0);
      drive_raw(0, 1'b1, 1'b0, 1'b0);
      drive_raw(0, 1'b0, 1'b0, 1'b0);
      if (sync_err) n_se++;
      if (i == 254 || i == 255) begin
        checks++;
        if (err_count !== 8'(i)) begin errors++; $display("FAIL sat_edge got %0d want %0d", err_count, i); end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", err_count); end
    checks++;
    if (n_se != 300) begin errors++; $display("FAIL sat_pulses got %0d want 300", n_se); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_sb got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hs_drop();
    test_de_err();
    test_reset_mid();
    test_gaps();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
